mem_access_ctrl: RTL and testbench

Sequencing controller for the external 16-bit SRAM that sits between the processor's MAR/MDR datapath and the SRAM pins. It arbitrates round-robin between two requesters, the CPU port and the memory-loader port. It drives the active-low CE/UB/LB/OE/WE strobes with a programmable number of access wait states and returns read data with a one-cycle acknowledge. It replaces direct wiring of the strobes from the control unit.

---
 rtl/mem_access_ctrl_if.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the two requester ports and the SRAM pins of mem_access_ctrl.
// The controller uses the slave view; requesters and the SRAM side use master.
interface mem_access_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        ld_req;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [15:0] ld_wdata;
    logic [15:0] ld_rdata;
    logic        ld_ack;
    logic [15:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in;
    logic        ce;
    logic        ub;
    logic        lb;
    logic        oe;
    logic        we;
    logic        busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack,
        input  addr, dq_out, dq_oe, ce, ub, lb, oe, we, busy,
        output dq_in
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack,
        output addr, dq_out, dq_oe, ce, ub, lb, oe, we, busy,
        input  dq_in
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// External 16-bit SRAM sequencer: round-robin CPU/loader arbitration, active-low
// strobes with programmable wait states, registered read data and one-cycle ack.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 32'd1);

    state_t      state_r, state_nxt_s;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic        gnt_ld_r, gnt_ld_nxt_s;
    logic        last_ld_r, last_ld_nxt_s;
    logic        win_ld_s;
    logic        is_wr_r, is_wr_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic [15:0] wdata_r, wdata_nxt_s;
    logic        ce_r, ce_nxt_s;
    logic        oe_r, oe_nxt_s;
    logic        we_r, we_nxt_s;
    logic        dq_oe_r, dq_oe_nxt_s;
    logic        cpu_ack_r, cpu_ack_nxt_s;
    logic        ld_ack_r, ld_ack_nxt_s;
    logic        busy_r;
    logic [15:0] cpu_rdata_r, ld_rdata_r;
    logic        capture_s;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        win_ld_s = 1'b0;
        if (bus.cpu_req && bus.ld_req) begin
            win_ld_s = ~last_ld_r;
        end else if (bus.ld_req) begin
            win_ld_s = 1'b1;
        end else begin
            win_ld_s = 1'b0;
        end
    end

    // Next-state logic; the winner's request fields are latched only on the grant.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        gnt_ld_nxt_s  = gnt_ld_r;
        last_ld_nxt_s = last_ld_r;
        is_wr_nxt_s   = is_wr_r;
        addr_nxt_s    = addr_r;
        wdata_nxt_s   = wdata_r;
        case (state_r)
            IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    state_nxt_s   = SETUP;
                    gnt_ld_nxt_s  = win_ld_s;
                    last_ld_nxt_s = win_ld_s;
                    is_wr_nxt_s   = win_ld_s ? bus.ld_we    : bus.cpu_we;
                    addr_nxt_s    = win_ld_s ? bus.ld_addr  : bus.cpu_addr;
                    wdata_nxt_s   = win_ld_s ? bus.ld_wdata : bus.cpu_wdata;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
                cnt_nxt_s   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            HOLD:    state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so every pin comes straight from a flop.
    always_comb begin
        ce_nxt_s      = 1'b1;
        oe_nxt_s      = 1'b1;
        we_nxt_s      = 1'b1;
        dq_oe_nxt_s   = 1'b0;
        cpu_ack_nxt_s = 1'b0;
        ld_ack_nxt_s  = 1'b0;
        case (state_nxt_s)
            SETUP: begin
                ce_nxt_s    = 1'b0;
                dq_oe_nxt_s = is_wr_nxt_s;
            end
            ACCESS: begin
                ce_nxt_s = 1'b0;
                if (is_wr_nxt_s) begin
                    we_nxt_s    = 1'b0;
                    dq_oe_nxt_s = 1'b1;
                end else begin
                    oe_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                ce_nxt_s    = 1'b0;
                dq_oe_nxt_s = is_wr_nxt_s;
            end
            DONE: begin
                cpu_ack_nxt_s = ~gnt_ld_nxt_s;
                ld_ack_nxt_s  = gnt_ld_nxt_s;
            end
            default: ce_nxt_s = 1'b1;
        endcase
    end

    // A read samples the SRAM on the edge that closes the last ACCESS cycle.
    assign capture_s = (state_r == ACCESS) && (cnt_r == 3'd0) && !is_wr_r;

    // FSM state, wait counter, arbitration history and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 3'd0;
            gnt_ld_r  <= 1'b0;
            last_ld_r <= 1'b1;
            is_wr_r   <= 1'b0;
            addr_r    <= 16'h0000;
            wdata_r   <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gnt_ld_r  <= gnt_ld_nxt_s;
            last_ld_r <= last_ld_nxt_s;
            is_wr_r   <= is_wr_nxt_s;
            addr_r    <= addr_nxt_s;
            wdata_r   <= wdata_nxt_s;
        end
    end

    // Registered strobes, acks and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_r      <= 1'b1;
            oe_r      <= 1'b1;
            we_r      <= 1'b1;
            dq_oe_r   <= 1'b0;
            cpu_ack_r <= 1'b0;
            ld_ack_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ce_r      <= ce_nxt_s;
            oe_r      <= oe_nxt_s;
            we_r      <= we_nxt_s;
            dq_oe_r   <= dq_oe_nxt_s;
            cpu_ack_r <= cpu_ack_nxt_s;
            ld_ack_r  <= ld_ack_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    // Per-port read data, held until that port completes another read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_r <= 16'h0000;
            ld_rdata_r  <= 16'h0000;
        end else if (capture_s && gnt_ld_r) begin
            ld_rdata_r <= bus.dq_in;
        end else if (capture_s) begin
            cpu_rdata_r <= bus.dq_in;
        end else begin
            cpu_rdata_r <= cpu_rdata_r;
            ld_rdata_r  <= ld_rdata_r;
        end
    end

    assign bus.addr      = addr_r;
    assign bus.dq_out    = wdata_r;
    assign bus.dq_oe     = dq_oe_r;
    assign bus.ce        = ce_r;
    assign bus.ub        = ce_r;
    assign bus.lb        = ce_r;
    assign bus.oe        = oe_r;
    assign bus.we        = we_r;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.ld_ack    = ld_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.ld_rdata  = ld_rdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: SRAM model on the pins, reference model of memory
// contents, arbitration history and access timing kept at transaction level.
module tb_mem_access_ctrl;
    localparam int W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();
    mem_access_ctrl_if bus7 ();

    mem_access_ctrl #(.WAIT_CYCLES(W)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_access_ctrl #(.WAIT_CYCLES(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          sram_ready = 1'b0;
    logic        pre_we   = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [15:0] pre_data = 16'h0000;

    logic        model_last_ld;
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_ld_rdata;

    function automatic logic [15:0] init_word(input int a);
        return 16'((a * 40503) ^ 32'h0000_3C5A);
    endfunction

    assign bus.dq_in  = sram[bus.addr];
    assign bus7.dq_in = bus7.addr ^ 16'hA5A5;

    // SRAM model: fills itself once, then takes preloads and pin-level writes.
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 65536; i++) sram[i] = init_word(i);
            sram_ready = 1'b1;
        end
        if (pre_we) sram[pre_addr] = pre_data;
        if (bus.ce === 1'b0 && bus.we === 1'b0) sram[bus.addr] = bus.dq_out;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick;
        pre_we     = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        n_vec++;
        if ({bus.ce, bus.ub, bus.lb, bus.oe, bus.we, bus.dq_oe, bus.busy, bus.cpu_ack, bus.ld_ack} !== 9'b111110000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 111110000", {bus.ce, bus.ub, bus.lb, bus.oe, bus.we, bus.dq_oe, bus.busy, bus.cpu_ack, bus.ld_ack});
        end
        n_vec++;
        if ({bus.addr, bus.dq_out, bus.cpu_rdata, bus.ld_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {bus.addr, bus.dq_out, bus.cpu_rdata, bus.ld_rdata});
        end
        n_vec++;
        if ({bus7.ce, bus7.oe, bus7.we, bus7.dq_oe, bus7.busy, bus7.cpu_ack} !== 6'b111000) begin
            n_err++;
            $display("FAIL reset_strobes_w7: got %b want 111000", {bus7.ce, bus7.oe, bus7.we, bus7.dq_oe, bus7.busy, bus7.cpu_ack});
        end
        #3 rst_n = 1'b1;
        model_last_ld = 1'b1;
        exp_cpu_rdata = 16'h0000;
        exp_ld_rdata  = 16'h0000;
        tick;
        n_vec++;
        if ({bus.ce, bus.oe, bus.we, bus.dq_oe, bus.busy} !== 5'b11100) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 11100", {bus.ce, bus.oe, bus.we, bus.dq_oe, bus.busy});
        end
    endtask

    task automatic test_cpu_read;
        int ack_cyc;
        logic [15:0] oe_mask, exp_oe;
        bit we_seen, addr_bad;
        preload(16'h0040, 16'hBEEF);
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0040;
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_req   = 1'b1;
        ack_cyc = -1; oe_mask = 16'h0; exp_oe = 16'h0; we_seen = 1'b0; addr_bad = 1'b0;
        for (int c = 1; c <= W + 6; c++) begin
            tick;
            if (c >= 2 && c <= W + 1) exp_oe[c] = 1'b1;
            if (bus.oe === 1'b0) oe_mask[c] = 1'b1;
            if (bus.we === 1'b0) we_seen = 1'b1;
            if (c <= W + 2 && bus.addr !== 16'h0040) addr_bad = 1'b1;
            if (c == 2) bus.cpu_addr = 16'hFFFF;
            if (c == W + 3) begin
                n_vec++;
                if (bus.cpu_rdata !== 16'hBEEF) begin
                    n_err++;
                    $display("FAIL cpu_read_data: got %h want beef", bus.cpu_rdata);
                end
            end
            if (bus.cpu_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc     = c;
                bus.cpu_req = 1'b0;
            end
        end
        model_last_ld = 1'b0;
        exp_cpu_rdata = 16'hBEEF;
        n_vec++;
        if (ack_cyc != W + 3) begin n_err++; $display("FAIL cpu_read_ack_cycle: got %0d want %0d", ack_cyc, W + 3); end
        n_vec++;
        if (oe_mask !== exp_oe) begin n_err++; $display("FAIL cpu_read_oe_window: got %b want %b", oe_mask, exp_oe); end
        n_vec++;
        if (we_seen) begin n_err++; $display("FAIL cpu_read_we: got WE low want never low"); end
        n_vec++;
        if (addr_bad) begin n_err++; $display("FAIL addr_latch: got addr change want 0040 held"); end
        n_vec++;
        if (bus.ld_rdata !== exp_ld_rdata) begin n_err++; $display("FAIL cpu_read_ld_rdata: got %h want %h", bus.ld_rdata, exp_ld_rdata); end
    endtask

    task automatic test_ld_write;
        int ack_cyc;
        logic [15:0] we_mask, exp_we, dq_mask, exp_dq;
        bit oe_seen;
        bus.ld_we    = 1'b1;
        bus.ld_addr  = 16'h1234;
        bus.ld_wdata = 16'h5A5A;
        bus.ld_req   = 1'b1;
        ack_cyc = -1; we_mask = 16'h0; exp_we = 16'h0; dq_mask = 16'h0; exp_dq = 16'h0; oe_seen = 1'b0;
        for (int c = 1; c <= W + 6; c++) begin
            tick;
            if (c >= 2 && c <= W + 1) exp_we[c] = 1'b1;
            if (c >= 1 && c <= W + 2) exp_dq[c] = 1'b1;
            if (bus.we === 1'b0) we_mask[c] = 1'b1;
            if (bus.dq_oe === 1'b1) dq_mask[c] = 1'b1;
            if (bus.oe === 1'b0) oe_seen = 1'b1;
            if (bus.ld_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc    = c;
                bus.ld_req = 1'b0;
            end
        end
        model_last_ld = 1'b1;
        ref_mem[16'h1234] = 16'h5A5A;
        n_vec++;
        if (ack_cyc != W + 3) begin n_err++; $display("FAIL ld_write_ack_cycle: got %0d want %0d", ack_cyc, W + 3); end
        n_vec++;
        if (we_mask !== exp_we) begin n_err++; $display("FAIL ld_write_we_window: got %b want %b", we_mask, exp_we); end
        n_vec++;
        if (dq_mask !== exp_dq) begin n_err++; $display("FAIL ld_write_dq_oe_window: got %b want %b", dq_mask, exp_dq); end
        n_vec++;
        if (oe_seen) begin n_err++; $display("FAIL ld_write_oe: got OE low want never low"); end
        n_vec++;
        if (sram[16'h1234] !== 16'h5A5A) begin n_err++; $display("FAIL ld_write_mem: got %h want 5a5a", sram[16'h1234]); end
        n_vec++;
        if ({bus.cpu_rdata, bus.ld_rdata} !== {exp_cpu_rdata, exp_ld_rdata}) begin
            n_err++;
            $display("FAIL ld_write_rdata: got %h want %h", {bus.cpu_rdata, bus.ld_rdata}, {exp_cpu_rdata, exp_ld_rdata});
        end
    endtask

    task automatic test_arbitration;
        int acks_seen, prev, exp_cyc;
        logic [15:0] a_cpu, a_ld, exp_rd;
        bit exp_ld;
        rst_n = 1'b0;
        tick;
        #3 rst_n = 1'b1;
        model_last_ld = 1'b1;
        exp_cpu_rdata = 16'h0000;
        exp_ld_rdata  = 16'h0000;
        tick;
        a_cpu = 16'($urandom);
        a_ld  = 16'($urandom);
        bus.cpu_we = 1'b0; bus.cpu_addr = a_cpu; bus.cpu_req = 1'b1;
        bus.ld_we  = 1'b0; bus.ld_addr  = a_ld;  bus.ld_req  = 1'b1;
        acks_seen = 0; prev = 0;
        for (int c = 1; c <= 3 * (W + 4) + 4; c++) begin
            tick;
            if (bus.cpu_ack === 1'b1 || bus.ld_ack === 1'b1) begin
                exp_ld  = ~model_last_ld;
                exp_cyc = (acks_seen == 0) ? W + 3 : prev + W + 4;
                exp_rd  = exp_ld ? ref_mem[a_ld] : ref_mem[a_cpu];
                n_vec++;
                if ({bus.cpu_ack, bus.ld_ack} !== (exp_ld ? 2'b01 : 2'b10)) begin
                    n_err++;
                    $display("FAIL arb_grant_%0d: got acks %b want %b", acks_seen, {bus.cpu_ack, bus.ld_ack}, exp_ld ? 2'b01 : 2'b10);
                end
                n_vec++;
                if (c != exp_cyc) begin n_err++; $display("FAIL arb_spacing_%0d: got cycle %0d want %0d", acks_seen, c, exp_cyc); end
                n_vec++;
                if ((exp_ld ? bus.ld_rdata : bus.cpu_rdata) !== exp_rd) begin
                    n_err++;
                    $display("FAIL arb_rdata_%0d: got %h want %h", acks_seen, exp_ld ? bus.ld_rdata : bus.cpu_rdata, exp_rd);
                end
                if (exp_ld) exp_ld_rdata = exp_rd; else exp_cpu_rdata = exp_rd;
                model_last_ld = exp_ld;
                prev = c;
                acks_seen++;
                if (acks_seen == 3) begin
                    bus.cpu_req = 1'b0;
                    bus.ld_req  = 1'b0;
                end
            end
        end
        n_vec++;
        if (acks_seen != 3) begin n_err++; $display("FAIL arb_ack_count: got %0d want 3", acks_seen); end
    endtask

    task automatic test_random;
        int pat, n_acks, ack_cyc;
        bit win_ld, got_ld, bad;
        logic w_we;
        logic [15:0] w_addr, w_data, e_cpu, e_ld;
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(0, 2);
            bus.cpu_we = 1'($urandom); bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
            bus.ld_we  = 1'($urandom); bus.ld_addr  = 16'($urandom); bus.ld_wdata  = 16'($urandom);
            bus.cpu_req = (pat != 1);
            bus.ld_req  = (pat != 0);
            win_ld = (pat == 2) ? ~model_last_ld : (pat == 1);
            w_we   = win_ld ? bus.ld_we    : bus.cpu_we;
            w_addr = win_ld ? bus.ld_addr  : bus.cpu_addr;
            w_data = win_ld ? bus.ld_wdata : bus.cpu_wdata;
            e_cpu = exp_cpu_rdata;
            e_ld  = exp_ld_rdata;
            if (!w_we && win_ld) e_ld = ref_mem[w_addr];
            if (!w_we && !win_ld) e_cpu = ref_mem[w_addr];
            n_acks = 0; ack_cyc = -1; got_ld = 1'b0; bad = 1'b0;
            for (int c = 1; c <= W + 6; c++) begin
                tick;
                if (c == 1) begin
                    bus.cpu_we = 1'($urandom); bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
                    bus.ld_we  = 1'($urandom); bus.ld_addr  = 16'($urandom); bus.ld_wdata  = 16'($urandom);
                end
                if ((bus.oe === 1'b0 && bus.we === 1'b0) || (bus.dq_oe === 1'b1 && bus.oe === 1'b0) ||
                    bus.ub !== bus.ce || bus.lb !== bus.ce) bad = 1'b1;
                if (bus.cpu_ack === 1'b1 || bus.ld_ack === 1'b1) begin
                    n_acks++;
                    ack_cyc = c;
                    got_ld  = bus.ld_ack;
                    bus.cpu_req = 1'b0;
                    bus.ld_req  = 1'b0;
                    n_vec++;
                    if ({bus.cpu_rdata, bus.ld_rdata} !== {e_cpu, e_ld}) begin
                        n_err++;
                        $display("FAIL rand_rdata_%0d: got %h want %h", it, {bus.cpu_rdata, bus.ld_rdata}, {e_cpu, e_ld});
                    end
                end
            end
            n_vec++;
            if (n_acks != 1 || ack_cyc != W + 3 || got_ld != win_ld) begin
                n_err++;
                $display("FAIL rand_ack_%0d: got %0d acks cycle %0d ld %b want 1 ack cycle %0d ld %b", it, n_acks, ack_cyc, got_ld, W + 3, win_ld);
            end
            n_vec++;
            if (bad) begin n_err++; $display("FAIL rand_strobes_%0d: got illegal strobe combination want legal", it); end
            if (w_we) begin
                ref_mem[w_addr] = w_data;
                n_vec++;
                if (sram[w_addr] !== w_data) begin n_err++; $display("FAIL rand_write_%0d: got %h want %h", it, sram[w_addr], w_data); end
            end
            exp_cpu_rdata = e_cpu;
            exp_ld_rdata  = e_ld;
            model_last_ld = win_ld;
        end
    endtask

    task automatic test_reset_mid;
        int ack_cyc;
        bit stray;
        bus.ld_we = 1'b1; bus.ld_addr = 16'h2222; bus.ld_wdata = 16'h1111; bus.ld_req = 1'b1;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.ce, bus.oe, bus.we, bus.dq_oe, bus.busy, bus.cpu_ack, bus.ld_ack} !== 7'b1110000) begin
            n_err++;
            $display("FAIL mid_reset_strobes: got %b want 1110000", {bus.ce, bus.oe, bus.we, bus.dq_oe, bus.busy, bus.cpu_ack, bus.ld_ack});
        end
        n_vec++;
        if ({bus.cpu_rdata, bus.ld_rdata} !== 32'h0) begin n_err++; $display("FAIL mid_reset_rdata: got %h want 0", {bus.cpu_rdata, bus.ld_rdata}); end
        bus.ld_req = 1'b0;
        #2 rst_n = 1'b1;
        model_last_ld = 1'b1;
        exp_cpu_rdata = 16'h0000;
        exp_ld_rdata  = 16'h0000;
        ref_mem[16'h2222] = 16'h1111;
        stray = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            tick;
            if (bus.cpu_ack !== 1'b0 || bus.ld_ack !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        n_vec++;
        if (stray) begin n_err++; $display("FAIL mid_reset_idle: got ack or busy want idle"); end
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2222; bus.cpu_req = 1'b1;
        ack_cyc = -1;
        for (int c = 1; c <= W + 5; c++) begin
            tick;
            if (bus.cpu_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc = c;
                bus.cpu_req = 1'b0;
                n_vec++;
                if (bus.cpu_rdata !== ref_mem[16'h2222]) begin
                    n_err++;
                    $display("FAIL post_reset_read: got %h want %h", bus.cpu_rdata, ref_mem[16'h2222]);
                end
            end
        end
        n_vec++;
        if (ack_cyc != W + 3) begin n_err++; $display("FAIL post_reset_ack: got %0d want %0d", ack_cyc, W + 3); end
        model_last_ld = 1'b0;
        exp_cpu_rdata = ref_mem[16'h2222];
    endtask

    task automatic test_wait7;
        int a1, a2;
        logic [31:0] oe_mask, exp_oe;
        tick;
        bus7.cpu_we = 1'b0; bus7.cpu_addr = 16'h0040; bus7.cpu_req = 1'b1;
        a1 = -1; a2 = -1; oe_mask = 32'h0; exp_oe = 32'h0;
        for (int c = 1; c <= 24; c++) begin
            tick;
            if ((c >= 2 && c <= 8) || (c >= 13 && c <= 19)) exp_oe[c] = 1'b1;
            if (bus7.oe === 1'b0) oe_mask[c] = 1'b1;
            if (bus7.cpu_ack === 1'b1) begin
                if (a1 < 0) begin
                    a1 = c;
                    n_vec++;
                    if (bus7.cpu_rdata !== (16'h0040 ^ 16'hA5A5)) begin
                        n_err++;
                        $display("FAIL w7_rdata: got %h want %h", bus7.cpu_rdata, 16'h0040 ^ 16'hA5A5);
                    end
                end else if (a2 < 0) begin
                    a2 = c;
                    bus7.cpu_req = 1'b0;
                end
            end
        end
        n_vec++;
        if (a1 != 10 || a2 != 21) begin n_err++; $display("FAIL w7_ack_cycles: got %0d,%0d want 10,21", a1, a2); end
        n_vec++;
        if (oe_mask !== exp_oe) begin n_err++; $display("FAIL w7_oe_window: got %b want %b", oe_mask, exp_oe); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = 16'h0000; bus.ld_wdata  = 16'h0000;
        bus7.cpu_req = 1'b0; bus7.cpu_we = 1'b0; bus7.cpu_addr = 16'h0000; bus7.cpu_wdata = 16'h0000;
        bus7.ld_req  = 1'b0; bus7.ld_we  = 1'b0; bus7.ld_addr  = 16'h0000; bus7.ld_wdata  = 16'h0000;
        test_reset;
        test_cpu_read;
        test_ld_write;
        test_arbitration;
        test_random;
        test_reset_mid;
        test_wait7;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
